pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 151 +++++++++++++++
 tb/tb_pc_fetch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch PC sequencer: drives imem requests, buffers one stalled word, handles redirects.
// Optional macro FETCH_MISALIGN_CHECK_EN: force redirect targets to word alignment and flag addr_err.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] pc_next,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        addr_err
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SKID,
        S_FLUSH
    } state_t;

    state_t            state, state_d;
    logic [XLEN-1:0]   pc_d, imem_addr_d, inst_d, inst_pc_d;
    logic [XLEN-1:0]   skid_data, skid_data_d, skid_pc, skid_pc_d;
    logic              imem_req_d, inst_valid_d;
    logic [XLEN-1:0]   redir_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};

    // One-cycle pulse for every misaligned redirect request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    assign redir_tgt = redirect_pc;
    assign addr_err  = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            imem_addr  <= RESET_PC;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            skid_data  <= '0;
            skid_pc    <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            imem_addr  <= imem_addr_d;
            imem_req   <= imem_req_d;
            inst_valid <= inst_valid_d;
            inst       <= inst_d;
            inst_pc    <= inst_pc_d;
            skid_data  <= skid_data_d;
            skid_pc    <= skid_pc_d;
        end
    end

    // Next-state and next-output logic; redirect outranks ack and stall
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        imem_addr_d  = imem_addr;
        inst_valid_d = inst_valid;
        inst_d       = inst;
        inst_pc_d    = inst_pc;
        skid_data_d  = skid_data;
        skid_pc_d    = skid_pc;

        case (state)
            S_IDLE: begin
                state_d     = S_FETCH;
                imem_addr_d = pc;
                if (redirect) begin
                    pc_d        = redir_tgt;
                    imem_addr_d = redir_tgt;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    pc_d         = redir_tgt;
                    inst_valid_d = 1'b0;
                    if (imem_ack) begin
                        imem_addr_d = redir_tgt;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else if (imem_ack && (!inst_valid || !stall)) begin
                    inst_d       = imem_rdata;
                    inst_pc_d    = imem_addr;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_next;
                    imem_addr_d  = pc_next;
                end else if (imem_ack) begin
                    skid_data_d = imem_rdata;
                    skid_pc_d   = imem_addr;
                    pc_d        = pc_next;
                    state_d     = S_SKID;
                end else if (inst_valid && !stall) begin
                    inst_valid_d = 1'b0;
                end
            end
            S_SKID: begin
                if (redirect) begin
                    pc_d         = redir_tgt;
                    imem_addr_d  = redir_tgt;
                    inst_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end else if (!stall) begin
                    inst_d      = skid_data;
                    inst_pc_d   = skid_pc;
                    imem_addr_d = pc;
                    state_d     = S_FETCH;
                end
            end
            S_FLUSH: begin
                // Wait out the stale access; its data is never delivered
                if (redirect) begin
                    pc_d = redir_tgt;
                end
                if (imem_ack) begin
                    imem_addr_d = redirect ? redir_tgt : pc;
                    state_d     = S_FETCH;
                end
            end
        endcase

        imem_req_d = (state_d == S_FETCH) || (state_d == S_FLUSH);
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a program-order scoreboard checked every cycle.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic        MIS_EN = 1'b1;
`else
    localparam logic        MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, pc_next, redirect_pc, imem_addr, imem_rdata, inst, inst_pc;
    logic        redirect, stall, imem_req, imem_ack, inst_valid, addr_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc = RST_PC;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_tgt = '0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_redir = 1'b0;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .pc_next(pc_next),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] tgt_of(input logic [31:0] r);
        return MIS_EN ? {r[31:2], 2'b00} : r;
    endfunction

    assign pc_next    = pc + 32'd4;
    assign imem_rdata = memw(imem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Program-order model: decode must see RST_PC, +4, ... restarting at each redirect target
    task automatic monitor();
        logic exp_err;
        if (!rst_n) begin
            exp_pc     = RST_PC;
            prev_req   = 1'b0;
            prev_redir = 1'b0;
        end else begin
            exp_err = prev_redir && (prev_tgt[1:0] != 2'b00) && MIS_EN;
            chk("addr_err_model", 32'(addr_err), 32'(exp_err));
            if (inst_valid)
                chk("inst_word", inst, memw(inst_pc));
            if (prev_redir)
                chk("kill_after_redirect", 32'(inst_valid), 32'd0);
            if (prev_req && !prev_ack && imem_req)
                chk("addr_hold", imem_addr, prev_addr);
            if (inst_valid && !stall) begin
                chk("inst_order", inst_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect)
                exp_pc = tgt_of(redirect_pc);
            prev_req   = imem_req;
            prev_ack   = imem_ack;
            prev_addr  = imem_addr;
            prev_redir = redirect;
            prev_tgt   = redirect_pc;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;

        // Streaming fetch after reset
        cyc();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_no_inst", 32'(inst_valid), 32'd0);
        imem_ack = 1'b1;
        cyc();
        chk("stream0_valid", 32'(inst_valid), 32'd1);
        chk("stream0_pc", inst_pc, 32'h0);
        chk("stream0_next_addr", imem_addr, 32'h4);
        cyc();
        chk("stream1_pc", inst_pc, 32'h4);
        chk("stream1_next_addr", imem_addr, 32'h8);
        cyc(); cyc();
        chk("stream3_pc", inst_pc, 32'hC);
        chk("stream3_next_addr", imem_addr, 32'h10);

        // Stall with full slot while 0x10 returns -> skid
        stall = 1'b1;
        cyc();
        chk("skid_req_low", 32'(imem_req), 32'd0);
        chk("skid_slot_pc", inst_pc, 32'hC);
        chk("skid_pc", pc, 32'h14);
        imem_ack = 1'b0;
        repeat (4) cyc();
        chk("skid_hold_req", 32'(imem_req), 32'd0);
        chk("skid_hold_slot", inst_pc, 32'hC);
        stall = 1'b0;
        cyc();
        chk("skid_drain_pc", inst_pc, 32'h10);
        chk("skid_resume_addr", imem_addr, 32'h14);
        chk("skid_resume_req", 32'(imem_req), 32'd1);
        imem_ack = 1'b1;
        cyc(); cyc(); cyc();
        chk("pre_flush_addr", imem_addr, 32'h20);

        // Redirect while 0x20 outstanding; ack arrives three cycles later
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
        cyc();
        chk("flush_addr_hold", imem_addr, 32'h20);
        chk("flush_valid", 32'(inst_valid), 32'd0);
        chk("flush_pc", pc, 32'h400);
        chk("flush_req", 32'(imem_req), 32'd1);
        redirect = 1'b0;
        cyc(); cyc();
        chk("flush_addr_hold2", imem_addr, 32'h20);
        imem_ack = 1'b1;
        cyc();
        chk("flush_done_addr", imem_addr, 32'h400);
        chk("flush_done_valid", 32'(inst_valid), 32'd0);
        cyc();
        chk("target_inst_pc", inst_pc, 32'h400);
        chk("target_inst_valid", 32'(inst_valid), 32'd1);
        cyc();

        // Redirect, stall and ack in the same cycle
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
        cyc();
        chk("prio_valid", 32'(inst_valid), 32'd0);
        chk("prio_addr", imem_addr, 32'h400);
        chk("prio_pc", pc, 32'h400);
        redirect = 1'b0; stall = 1'b0;
        cyc();
        chk("prio_inst_pc", inst_pc, 32'h400);

        // Fill the skid, then reset mid-cycle
        stall = 1'b1;
        cyc();
        chk("skid2_req_low", 32'(imem_req), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc, RST_PC);
        chk("async_rst_req", 32'(imem_req), 32'd0);
        chk("async_rst_valid", 32'(inst_valid), 32'd0);
        chk("async_rst_addr", imem_addr, RST_PC);
        stall = 1'b0;
        cyc(); cyc();
        chk("rst_ack_ignored", 32'(inst_valid), 32'd0);

        // Redirect during the idle cycle after reset
        rst_n = 1'b1; imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        cyc();
        chk("idle_redir_addr", imem_addr, 32'h200);
        chk("idle_redir_pc", pc, 32'h200);
        chk("idle_redir_req", 32'(imem_req), 32'd1);

        // Misaligned redirect target
        redirect_pc = 32'h102;
        cyc();
        chk("mis_pc", pc, MIS_EN ? 32'h100 : 32'h102);
        chk("mis_err", 32'(addr_err), 32'(MIS_EN));
        chk("mis_addr_hold", imem_addr, 32'h200);
        redirect = 1'b0; imem_ack = 1'b1;
        cyc();
        chk("mis_err_drop", 32'(addr_err), 32'd0);
        chk("mis_fetch_addr", imem_addr, MIS_EN ? 32'h100 : 32'h102);
        cyc();
        chk("mis_inst_pc", inst_pc, MIS_EN ? 32'h100 : 32'h102);
        chk("mis_inst_valid", 32'(inst_valid), 32'd1);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
